// File: rtl/md_issue_ctrl_pkg.sv
// Shared MDOp/class codes, FSM states and default latencies
// for the multiply/divide issue controller.
package md_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    MUDI_NONE  = 3'd0,
    MUDI_MULT  = 3'd1,
    MUDI_MULTU = 3'd2,
    MUDI_DIV   = 3'd3,
    MUDI_DIVU  = 3'd4,
    MUDI_MTHI  = 3'd5,
    MUDI_MTLO  = 3'd6
  } mudi_e;

  typedef enum logic [3:0] {
    MD_CLS_NONE  = 4'd0,
    MD_CLS_MULT  = 4'd1,
    MD_CLS_MULTU = 4'd2,
    MD_CLS_DIV   = 4'd3,
    MD_CLS_DIVU  = 4'd4,
    MD_CLS_MTHI  = 4'd5,
    MD_CLS_MTLO  = 4'd6,
    MD_CLS_MFHI  = 4'd7,
    MD_CLS_MFLO  = 4'd8
  } md_cls_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MUL_CYCLES = 5;
  localparam int MD_DIV_CYCLES = 10;
  localparam int MD_CNT_W      = 4;

endpackage

// File: rtl/md_issue_ctrl_decode.sv
// E-stage HI/LO class decode: issue flag, MDOp code,
// HI/LO read select and shadow-counter load value.
module md_cls_decode
  import md_issue_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MD_MUL_CYCLES,
  parameter int DIV_CYCLES = MD_DIV_CYCLES,
  parameter int CNT_W      = MD_CNT_W
) (
  input  logic             e_valid_i,
  input  logic [3:0]       e_md_op_i,
  output logic             is_md_o,
  output logic [2:0]       md_op_o,
  output logic             mf_sel_hi_o,
  output logic [CNT_W-1:0] load_o
);

  mudi_e op;

  always_comb begin
    is_md_o = 1'b0;
    op      = MUDI_NONE;
    load_o  = '0;
    if (e_valid_i) begin
      unique case (e_md_op_i)
        MD_CLS_MULT: begin
          is_md_o = 1'b1;
          op      = MUDI_MULT;
          load_o  = CNT_W'(MUL_CYCLES);
        end
        MD_CLS_MULTU: begin
          is_md_o = 1'b1;
          op      = MUDI_MULTU;
          load_o  = CNT_W'(MUL_CYCLES);
        end
        MD_CLS_DIV: begin
          is_md_o = 1'b1;
          op      = MUDI_DIV;
          load_o  = CNT_W'(DIV_CYCLES);
        end
        MD_CLS_DIVU: begin
          is_md_o = 1'b1;
          op      = MUDI_DIVU;
          load_o  = CNT_W'(DIV_CYCLES);
        end
        MD_CLS_MTHI: op = MUDI_MTHI;
        MD_CLS_MTLO: op = MUDI_MTLO;
        default: ;
      endcase
    end
  end

  assign md_op_o     = op;
  assign mf_sel_hi_o = (e_md_op_i == MD_CLS_MFHI);

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue/hazard control in front of the mult/div unit with a
// shadow latency counter cross-checked against the unit's Busy.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MD_MUL_CYCLES,
  parameter int DIV_CYCLES = MD_DIV_CYCLES,
  parameter int CNT_W      = MD_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       e_valid,
  input  logic [3:0] e_md_op,
  input  logic       d_md_use,
  input  logic       md_busy,
  output logic       md_start,
  output logic [2:0] md_op,
  output logic       md_stall,
  output logic       mf_sel_hi,
  output logic       err_mismatch
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             arm_q;
  logic             is_md;
  logic             start_now;
  logic [CNT_W-1:0] load;

  md_cls_decode #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES),
    .CNT_W     (CNT_W)
  ) u_dec (
    .e_valid_i  (e_valid),
    .e_md_op_i  (e_md_op),
    .is_md_o    (is_md),
    .md_op_o    (md_op),
    .mf_sel_hi_o(mf_sel_hi),
    .load_o     (load)
  );

  assign start_now = is_md && (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_now) begin
          state_d = ST_RUN;
          cnt_d   = load;
        end
        // Busy right after reset release may be stale.
        if (md_busy && arm_q) err_d = 1'b1;
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (!md_busy || is_md) err_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      arm_q   <= 1'b1;
    end
  end

  assign md_start     = start_now;
  assign md_stall     = d_md_use &&
                        ((state_q == ST_RUN) || start_now);
  assign err_mismatch = err_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Randomized and directed bench for md_issue_ctrl against
// a cycle-budget reference model of the mult/div pipeline.
module tb_md_issue_ctrl;
  import md_issue_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       e_valid = 1'b0;
  logic [3:0] e_md_op = 4'd0;
  logic       d_md_use = 1'b0;
  logic       md_busy = 1'b0;
  logic       md_start;
  logic [2:0] md_op;
  logic       md_stall;
  logic       mf_sel_hi;
  logic       err_mismatch;

  int n_chk = 0;
  int n_err = 0;

  int   m_rem = 0;
  logic m_err = 1'b0;
  logic m_armed = 1'b0;
  int   stall_seen = 0;
  logic last_start = 1'b0;

  md_issue_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .e_valid     (e_valid),
    .e_md_op     (e_md_op),
    .d_md_use    (d_md_use),
    .md_busy     (md_busy),
    .md_start    (md_start),
    .md_op       (md_op),
    .md_stall    (md_stall),
    .mf_sel_hi   (mf_sel_hi),
    .err_mismatch(err_mismatch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input logic [3:0] op);
    return (op == 4'd3 || op == 4'd4) ? 10 : 5;
  endfunction

  function automatic logic md_cls(input logic [3:0] op);
    return op >= 4'd1 && op <= 4'd4;
  endfunction

  task automatic mdl_edge(input logic ismd,
                          input logic [3:0] op);
    if (m_rem > 0 && !md_busy) m_err = 1'b1;
    if (m_rem == 0 && md_busy && m_armed) m_err = 1'b1;
    if (m_rem > 0 && ismd) m_err = 1'b1;
    m_armed = 1'b1;
    if (m_rem > 0) m_rem--;
    else if (ismd) m_rem = lat_of(op);
  endtask

  task automatic step(input logic v,
                      input logic [3:0] op,
                      input logic du,
                      input logic kill);
    logic ismd, st, stl;
    logic [2:0] eop;
    @(negedge clk);
    e_valid  = v;
    e_md_op  = op;
    d_md_use = du;
    md_busy  = (m_rem > 0) && !kill;
    #1;
    ismd = v && md_cls(op);
    st   = ismd && (m_rem == 0);
    stl  = du && (m_rem > 0 || st);
    eop  = (v && op >= 4'd1 && op <= 4'd6) ? op[2:0] : 3'd0;
    chk("start", 32'(md_start), 32'(st));
    chk("stall", 32'(md_stall), 32'(stl));
    chk("md_op", 32'(md_op), 32'(eop));
    chk("sel_hi", 32'(mf_sel_hi), 32'(op == 4'd7));
    chk("err", 32'(err_mismatch), 32'(m_err));
    if (md_stall) stall_seen++;
    last_start = md_start;
    @(posedge clk);
    mdl_edge(ismd, op);
  endtask

  task automatic do_reset;
    rst = 1'b0;
    e_valid = 1'b0;
    e_md_op = 4'd0;
    d_md_use = 1'b0;
    md_busy = 1'b0;
    m_rem = 0;
    m_err = 1'b0;
    m_armed = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_start", 32'(md_start), 0);
    chk("rst_stall", 32'(md_stall), 0);
    chk("rst_op", 32'(md_op), 0);
    chk("rst_err", 32'(err_mismatch), 0);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    step(0, 4'd0, 0, 0);

    // mult with mfhi waiting in D
    stall_seen = 0;
    step(1, 4'd1, 1, 0);
    chk("mul_start", 32'(last_start), 1);
    repeat (5) step(0, 4'd0, 1, 0);
    step(1, 4'd7, 0, 0);
    chk("mul_stall_len", 32'(stall_seen), 6);
    chk("mfhi_sel", 32'(mf_sel_hi), 1);

    // divu with unrelated D
    stall_seen = 0;
    step(1, 4'd4, 0, 0);
    repeat (10) step(1, 4'd0, 0, 0);
    chk("divu_stall", 32'(stall_seen), 0);
    step(1, 4'd2, 0, 0);
    chk("divu_idle", 32'(last_start), 1);
    repeat (5) step(0, 4'd0, 0, 0);

    // mtlo while idle
    stall_seen = 0;
    step(1, 4'd6, 1, 0);
    chk("mtlo_stall", 32'(stall_seen), 0);
    step(1, 4'd1, 0, 0);
    chk("mtlo_idle", 32'(last_start), 1);
    repeat (5) step(0, 4'd0, 0, 0);

    // reset pulse in mult RUN cycle 2
    step(1, 4'd0, 0, 0);
    step(1, 4'd1, 1, 0);
    step(0, 4'd0, 1, 0);
    @(negedge clk);
    e_valid = 1'b0;
    d_md_use = 1'b1;
    rst = 1'b0;
    #1;
    chk("arst_stall", 32'(md_stall), 0);
    chk("arst_start", 32'(md_start), 0);
    m_rem = 0;
    m_err = 1'b0;
    m_armed = 1'b0;
    md_busy = 1'b0;
    #3;
    rst = 1'b1;
    @(posedge clk);
    mdl_edge(1'b0, 4'd0);
    stall_seen = 0;
    step(1, 4'd1, 1, 0);
    repeat (5) step(0, 4'd0, 1, 0);
    step(1, 4'd8, 0, 0);
    chk("arst_mul_len", 32'(stall_seen), 6);
    chk("arst_err", 32'(err_mismatch), 0);

    // randomized legal traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      if (m_rem > 0) begin
        int k = $urandom_range(0, 4);
        op = (k == 0) ? 4'd0 : 4'(k + 4);
      end else begin
        op = 4'($urandom_range(0, 8));
      end
      step(1'($urandom_range(0, 1)), op,
           1'($urandom_range(0, 1)), 0);
    end
    repeat (11) step(0, 4'd0, 0, 0);
    chk("rand_err", 32'(err_mismatch), 0);

    // busy drops in div RUN cycle 4
    step(1, 4'd3, 0, 0);
    repeat (3) step(0, 4'd0, 0, 0);
    step(0, 4'd0, 0, 1);
    repeat (12) step(0, 4'd0, 0, 0);
    chk("busy_sticky", 32'(err_mismatch), 1);

    // issue attempt during RUN is ignored
    do_reset();
    step(0, 4'd0, 0, 0);
    step(1, 4'd1, 0, 0);
    step(1, 4'd3, 1, 0);
    chk("run_issue", 32'(last_start), 0);
    repeat (4) step(0, 4'd0, 0, 0);
    step(1, 4'd2, 0, 0);
    chk("run_noreload", 32'(last_start), 1);
    chk("run_err", 32'(err_mismatch), 1);
    repeat (6) step(0, 4'd0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
